// File: rtl/mmu_refill.sv
// mmu_refill: hardware page-table walker for the two-bank page-map MMU.
//
// On an MMU miss it captures the MMU fault register, reads the matching PTE
// from the memory-resident page table and writes it back to the MMU through
// the register-write port (virt-write form, bit0=1). Faults that cannot be
// refilled (engine disabled, protection fault, invalid PTE) are handed to
// software as a one-cycle sw_fault pulse.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   enable                 refill engine enabled (0: every fault -> sw_fault)
//   ptbase                 page-table base, upper word-address bits
//   fault_in               MMU fault pulse (fault_reg valid one cycle later)
//   fault_reg              MMU fault register read-back
//   abort                  pipeline flush; abandon the walk
//   mem_req/mem_addr       PTE read request, held until mem_ack
//   mem_ack/mem_rdata      one-cycle read response
//   mmu_reg_write/_data    one-cycle MMU register write
//   busy                   walk in progress
//   refill_done            faulting access may retry
//   sw_fault               raise MMU trap to software
module mmu_refill #(
    parameter int RV    = 16,
    parameter int PA    = 16,
    parameter int VA    = 16,
    parameter int NMMU  = 8,
    localparam int SEL   = $clog2(NMMU),
    localparam int PTB_W = PA - RV/16 - (SEL + 2),
    localparam int MAW   = PA - RV/16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [PTB_W-1:0] ptbase,
    input  logic             fault_in,
    input  logic [RV-1:0]    fault_reg,
    input  logic             abort,
    output logic             mem_req,
    output logic [MAW-1:0]   mem_addr,
    input  logic             mem_ack,
    input  logic [RV-1:0]    mem_rdata,
    output logic             mmu_reg_write,
    output logic [RV-1:0]    mmu_reg_data,
    output logic             busy,
    output logic             refill_done,
    output logic             sw_fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPT,
        S_REQ,
        S_WRITE,
        S_DRAIN
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_mem_req;
    logic [MAW-1:0]   r_mem_addr;
    logic [RV-1:0]    r_wdata;
    logic             r_pte_valid;

    // Fault register fields
    logic [SEL-1:0] w_vpage;
    logic           w_ins;
    logic           w_sup;
    logic           w_miss;

    assign w_vpage = fault_reg[RV-1 -: SEL];
    assign w_ins   = fault_reg[3];
    assign w_sup   = fault_reg[2];
    assign w_miss  = fault_reg[1];

    // Untouched fault-register bits and PTE bit0 carry nothing for the walk.
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, fault_reg[RV-SEL-1:4], fault_reg[0], mem_rdata[0]};

    // The strobes are decoded from the registered state rather than
    // registered themselves: abort must be able to kill them in the very
    // cycle it arrives, and the CAPT decision depends on fault_reg, which
    // is only valid in that cycle.
    logic w_trap_capt;
    logic w_trap_pte;
    logic w_fill;

    assign w_trap_capt = (r_state == S_CAPT)  && !abort && (!enable || !w_miss);
    assign w_trap_pte  = (r_state == S_WRITE) && !abort && !r_pte_valid;
    assign w_fill      = (r_state == S_WRITE) && !abort &&  r_pte_valid;

    assign sw_fault      = w_trap_capt || w_trap_pte;
    assign mmu_reg_write = w_fill;
    assign refill_done   = w_fill;
    assign busy          = r_busy;
    assign mem_req       = r_mem_req;
    assign mem_addr      = r_mem_addr;
    assign mmu_reg_data  = r_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_wdata     <= '0;
            r_pte_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fault_in) begin
                        r_state <= S_CAPT;
                        r_busy  <= 1'b1;
                    end
                end
                S_CAPT: begin
                    if (abort || !enable || !w_miss) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        // PTE index: one entry per {sup, ins, vpage} slot
                        r_mem_addr <= {ptbase, w_sup, w_ins, w_vpage};
                        r_mem_req  <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (abort) begin
                        // Request already issued; if the ack is not here
                        // yet it must still be absorbed before going idle.
                        r_mem_req <= 1'b0;
                        if (mem_ack) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_wdata     <= {mem_rdata[RV-1:1], 1'b1};
                        r_pte_valid <= mem_rdata[1];
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_DRAIN: begin
                    if (mem_ack) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_refill.sv
module tb_mmu_refill;
  localparam int RV    = 16;
  localparam int PTB_W = 10;
  localparam int MAW   = 15;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [PTB_W-1:0] ptbase;
  logic             fault_in;
  logic [RV-1:0]    fault_reg;
  logic             abort;
  logic             mem_req;
  logic [MAW-1:0]   mem_addr;
  logic             mem_ack;
  logic [RV-1:0]    mem_rdata;
  logic             mmu_reg_write;
  logic [RV-1:0]    mmu_reg_data;
  logic             busy;
  logic             refill_done;
  logic             sw_fault;

  mmu_refill dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ptbase(ptbase),
    .fault_in(fault_in), .fault_reg(fault_reg), .abort(abort),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mmu_reg_write(mmu_reg_write),
    .mmu_reg_data(mmu_reg_data), .busy(busy), .refill_done(refill_done),
    .sw_fault(sw_fault)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One fault walk. Cycle 0 carries fault_in; the memory answers at cycle
  // 2+dly. aph: 0 none, 1 abort in CAPT cycle, 2 abort at REQ cycle ak,
  // 3 abort in WRITE cycle. stray: extra fault_in pulses while busy.
  task automatic run_walk(input string nm, input logic [PTB_W-1:0] ptb,
                          input logic [RV-1:0] freg, input bit en,
                          input logic [RV-1:0] pte, input int dly,
                          input int aph, input int ak, input bit stray);
    int eb, er, ewr, edone, esw, eoff, eaddr, edata;
    int ob, orq, owr, odone, osw, woff, doff, soff, addr_bad, viol;
    logic [RV-1:0] odata;
    bit prev;
    // Reference: outcome from the walk rules, in plain arithmetic.
    eaddr = int'(ptb) * 32 + int'(freg[2]) * 16 + int'(freg[3]) * 8 + int'(freg[15:13]);
    edata = int'(pte) | 1;
    er = 0; ewr = 0; edone = 0; esw = 0; eoff = -1;
    if (aph == 1) begin
      eb = 1;
    end else if (!en || !freg[1]) begin
      eb = 1; esw = 1; eoff = 1;
    end else if (aph == 2) begin
      eb = 2 + dly; er = ak + 1;
    end else begin
      eb = 3 + dly; er = dly + 1;
      if (aph != 3) begin
        eoff = 3 + dly;
        if (pte[1]) begin ewr = 1; edone = 1; end
        else esw = 1;
      end
    end

    ob = 0; orq = 0; owr = 0; odone = 0; osw = 0; woff = -1; doff = -1; soff = -1;
    addr_bad = 0; viol = 0; prev = 1'b0; odata = '0;
    for (int c = 0; c < dly + 8; c++) begin
      @(posedge clk); #1;
      ptbase    = ptb;
      fault_reg = freg;
      enable    = en;
      fault_in  = (c == 0) || (stray && c >= 1 && c <= eb && $urandom_range(1, 0) == 1);
      mem_ack   = (c == 2 + dly);
      mem_rdata = mem_ack ? pte : 16'($urandom);
      abort     = (aph == 1 && c == 1) || (aph == 2 && c == 2 + ak) || (aph == 3 && c == 3 + dly);
      @(negedge clk);
      if (busy) ob++;
      if (mem_req) begin
        orq++;
        if (int'(mem_addr) != eaddr) addr_bad++;
      end
      if (mmu_reg_write) begin owr++; woff = c; odata = mmu_reg_data; end
      if (refill_done) begin odone++; doff = c; end
      if (sw_fault) begin osw++; soff = c; end
      if ((refill_done && sw_fault) || ((refill_done || sw_fault || mmu_reg_write) && !busy) ||
          (prev && (refill_done || sw_fault)))
        viol++;
      prev = refill_done || sw_fault;
    end
    @(posedge clk); #1;
    fault_in = 1'b0; mem_ack = 1'b0; abort = 1'b0;

    chk({nm, ".busy_cycles"}, ob, eb);
    chk({nm, ".req_cycles"}, orq, er);
    chk({nm, ".writes"}, owr, ewr);
    chk({nm, ".dones"}, odone, edone);
    chk({nm, ".sw_faults"}, osw, esw);
    chk({nm, ".addr_errs"}, addr_bad, 0);
    chk({nm, ".pulse_rule_errs"}, viol, 0);
    if (ewr) begin
      chk({nm, ".wdata"}, odata, edata);
      chk({nm, ".write_cycle"}, woff, eoff);
      chk({nm, ".done_cycle"}, doff, eoff);
    end
    if (esw) chk({nm, ".sw_cycle"}, soff, eoff);
    @(negedge clk);
    chk({nm, ".idle_after"}, busy, 0);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; ptbase = '0; fault_in = 1'b0; fault_reg = '0;
    abort = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.outs", {mem_req, mmu_reg_write, busy, refill_done, sw_fault}, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.data", mmu_reg_data, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Directed cases
    run_walk("basic", 10'h001, 16'h600A, 1'b1, 16'hA006, 0, 0, 0, 1'b0);
    chk("basic.addr_val", mem_addr, 15'h02B);
    run_walk("prot", 10'h001, 16'h2004, 1'b1, 16'hA006, 0, 0, 0, 1'b0);
    run_walk("inval_pte", 10'h123, 16'h600A, 1'b1, 16'h4004, 1, 0, 0, 1'b0);
    run_walk("slow_stray", 10'h2A5, 16'hE00E, 1'b1, 16'h6006, 5, 0, 0, 1'b1);
    run_walk("abort_req", 10'h001, 16'h600A, 1'b1, 16'hA006, 3, 2, 0, 1'b0);
    run_walk("abort_ack", 10'h0F0, 16'h400A, 1'b1, 16'hA006, 2, 2, 2, 1'b0);
    run_walk("abort_capt", 10'h001, 16'h600A, 1'b1, 16'hA006, 0, 1, 0, 1'b0);
    run_walk("abort_write", 10'h001, 16'h600A, 1'b1, 16'hA006, 1, 3, 0, 1'b0);

    // Reset mid-walk, then a stray ack
    @(posedge clk); #1;
    ptbase = 10'h001; fault_reg = 16'h600A; enable = 1'b1; fault_in = 1'b1;
    @(posedge clk); #1 fault_in = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid.req_before", mem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid.outs", {mem_req, mmu_reg_write, busy, refill_done, sw_fault}, 0);
    chk("rstmid.addr", mem_addr, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b1; mem_rdata = 16'hA006;
    @(negedge clk);
    chk("rstmid.stray", {mem_req, mmu_reg_write, busy, refill_done, sw_fault}, 0);
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    chk("rstmid.stray_after", {mem_req, mmu_reg_write, busy, refill_done, sw_fault}, 0);
    run_walk("disabled", 10'h001, 16'h600A, 1'b0, 16'hA006, 0, 0, 0, 1'b0);

    // Randomized walks
    for (int n = 0; n < 40; n++) begin
      logic [RV-1:0] fr, pt;
      int d, ph, k;
      fr = 16'($urandom);
      fr[1] = ($urandom_range(3, 0) != 0);
      fr[0] = 1'b0;
      pt = 16'($urandom);
      pt[1] = ($urandom_range(3, 0) != 0);
      d  = $urandom_range(6, 0);
      ph = $urandom_range(5, 0);
      if (ph > 3) ph = 0;
      k  = $urandom_range(d, 0);
      run_walk("rand", 10'($urandom), fr, ($urandom_range(7, 0) != 0), pt, d, ph, k,
               bit'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
